// File: rtl/store_ex_controller.sv
// Purpose     : drains result rows of tile C from the output buffer into memory (write beats).
// Latency     : first address issued in the start cycle, first beat >= 1 cycle later, then 1 row/cycle.
// Backpressure: stalls indefinitely while out_buff_valid (or mem_ready) is low; aborts when can_store drops.
//
// Optional feature macro: STORE_MEM_READY_EN
//   defined   -> adds input mem_ready; a beat additionally requires mem_ready=1.
//   undefined -> no mem_ready port; the memory interface is treated as always ready.
//
// Ports
//   clk, rst                 clock; asynchronous active-high reset
//   can_store                load/execute FSM grants the shared memory interface to this block
//   tile_C_addr/_stride      row-0 address and row stride of tile C (sampled at start)
//   msize / nsize            row count / elements per row (sampled at start)
//   out_buff_valid           output buffer holds at least one complete row
//   out_buff_read            pop one row from the output buffer
//   gen_addr_store           load the address generator with next_row_addr_store
//   next_row_addr_store      next row address for the address generator
//   interface_en_store       memory interface beat enable
//   interface_control_store  beat length (latched nsize)
//   interface_rdwr_store     1 = write, only together with interface_en_store
//   mem_ready                (STORE_MEM_READY_EN only) memory interface can accept a beat
//   done_store               final row write issued this cycle
//   busy_store               controller is not idle
module store_ex_controller #(
    parameter int ADDR_W = 32,
    parameter int SIZE_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              can_store,
    input  logic [ADDR_W-1:0] tile_C_addr,
    input  logic [ADDR_W-1:0] tile_C_stride,
    input  logic [SIZE_W-1:0] msize,
    input  logic [SIZE_W-1:0] nsize,
    input  logic              out_buff_valid,
    output logic              out_buff_read,
    output logic              gen_addr_store,
    output logic [ADDR_W-1:0] next_row_addr_store,
    output logic              interface_en_store,
    output logic [SIZE_W-1:0] interface_control_store,
    output logic              interface_rdwr_store,
`ifdef STORE_MEM_READY_EN
    input  logic              mem_ready,
`endif
    output logic              done_store,
    output logic              busy_store
);

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [SIZE_W-1:0] row_cnt_q, row_cnt_d;
    logic [ADDR_W-1:0] row_addr_q, row_addr_d;
    logic [SIZE_W-1:0] m_q, m_d;
    logic [SIZE_W-1:0] n_q, n_d;
    logic [ADDR_W-1:0] stride_q, stride_d;

    logic              mem_rdy;
    logic              beat;
    logic [SIZE_W-1:0] row_cnt_inc;
    logic              last_row;
    logic [ADDR_W-1:0] row_addr_nxt;

    // Unregistered versions of the outputs; gated by rst below so nothing
    // leaks out combinationally while reset is held.
    logic              read_c;
    logic              gen_c;
    logic [ADDR_W-1:0] addr_c;
    logic              en_c;
    logic [SIZE_W-1:0] ctrl_c;
    logic              rdwr_c;
    logic              done_c;

`ifdef STORE_MEM_READY_EN
    assign mem_rdy = mem_ready;
`else
    assign mem_rdy = 1'b1;
`endif

    // An empty tile (m_q == 0) never beats; it finishes with a bare done pulse.
    assign beat         = (state_q == WRITE) && can_store && out_buff_valid && mem_rdy && (m_q != '0);
    // Compare stays SIZE_W wide: with msize = 2^SIZE_W-1 the last increment still fits.
    assign row_cnt_inc  = row_cnt_q + 1'b1;
    assign last_row     = (row_cnt_inc == m_q);
    // Address arithmetic wraps modulo 2^ADDR_W by construction.
    assign row_addr_nxt = row_addr_q + stride_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            row_cnt_q  <= '0;
            row_addr_q <= '0;
            m_q        <= '0;
            n_q        <= '0;
            stride_q   <= '0;
        end else begin
            state_q    <= state_d;
            row_cnt_q  <= row_cnt_d;
            row_addr_q <= row_addr_d;
            m_q        <= m_d;
            n_q        <= n_d;
            stride_q   <= stride_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        row_cnt_d  = row_cnt_q;
        row_addr_d = row_addr_q;
        m_d        = m_q;
        n_d        = n_q;
        stride_d   = stride_q;

        read_c     = 1'b0;
        gen_c      = 1'b0;
        addr_c     = '0;
        en_c       = 1'b0;
        ctrl_c     = '0;
        rdwr_c     = 1'b0;
        done_c     = 1'b0;

        case (state_q)
            IDLE: begin
                if (can_store) begin
                    // Sample the tile configuration and hand row 0's address to
                    // the generator in this same cycle.
                    m_d        = msize;
                    n_d        = nsize;
                    stride_d   = tile_C_stride;
                    row_addr_d = tile_C_addr;
                    row_cnt_d  = '0;
                    gen_c      = 1'b1;
                    addr_c     = tile_C_addr;
                    state_d    = WRITE;
                end
            end

            WRITE: begin
                if (!can_store) begin
                    // Interface taken away: abandon the tile without done.
                    state_d = IDLE;
                end else if (m_q == '0) begin
                    done_c  = 1'b1;
                    state_d = IDLE;
                end else if (beat) begin
                    en_c      = 1'b1;
                    rdwr_c    = 1'b1;
                    ctrl_c    = n_q;
                    read_c    = 1'b1;
                    row_cnt_d = row_cnt_inc;
                    if (last_row) begin
                        done_c  = 1'b1;
                        state_d = IDLE;
                    end else begin
                        // Pre-load the generator with the following row's address.
                        gen_c      = 1'b1;
                        addr_c     = row_addr_nxt;
                        row_addr_d = row_addr_nxt;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign out_buff_read           = read_c & ~rst;
    assign gen_addr_store          = gen_c & ~rst;
    assign next_row_addr_store     = rst ? '0 : addr_c;
    assign interface_en_store      = en_c & ~rst;
    assign interface_control_store = rst ? '0 : ctrl_c;
    assign interface_rdwr_store    = rdwr_c & ~rst;
    assign done_store              = done_c & ~rst;
    assign busy_store              = (state_q == WRITE) & ~rst;

endmodule

// File: tb/tb_store_ex_controller.sv
// Purpose     : self-checking bench for store_ex_controller using directed vector tables.
// Latency     : inputs change on the falling edge; outputs are compared 1 time unit later.
// Backpressure: exercised through out_buff_valid gaps, can_store aborts and (with the macro) mem_ready.
module tb_store_ex_controller;

    logic        clk;
    logic        rst;
    logic        can_store;
    logic [31:0] tile_C_addr;
    logic [31:0] tile_C_stride;
    logic [4:0]  msize;
    logic [4:0]  nsize;
    logic        out_buff_valid;
    logic        out_buff_read;
    logic        gen_addr_store;
    logic [31:0] next_row_addr_store;
    logic        interface_en_store;
    logic [4:0]  interface_control_store;
    logic        interface_rdwr_store;
    logic        mem_ready;
    logic        done_store;
    logic        busy_store;

    int checks = 0;
    int errors = 0;

    store_ex_controller #(.ADDR_W(32), .SIZE_W(5)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .can_store               (can_store),
        .tile_C_addr             (tile_C_addr),
        .tile_C_stride           (tile_C_stride),
        .msize                   (msize),
        .nsize                   (nsize),
        .out_buff_valid          (out_buff_valid),
        .out_buff_read           (out_buff_read),
        .gen_addr_store          (gen_addr_store),
        .next_row_addr_store     (next_row_addr_store),
        .interface_en_store      (interface_en_store),
        .interface_control_store (interface_control_store),
        .interface_rdwr_store    (interface_rdwr_store),
`ifdef STORE_MEM_READY_EN
        .mem_ready               (mem_ready),
`endif
        .done_store              (done_store),
        .busy_store              (busy_store)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs packed as {read, gen, addr[31:0], en, ctrl[4:0], rdwr, done, busy}.
    typedef struct {
        logic        rst;
        logic        can;
        logic        valid;
        logic        ready;
        logic [31:0] addr;
        logic [31:0] stride;
        logic [4:0]  m;
        logic [4:0]  n;
        logic [42:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [42:0] ex(input logic rd, input logic gen, input logic [31:0] a,
                                       input logic en, input logic [4:0] c, input logic rw,
                                       input logic dn, input logic bsy);
        return {rd, gen, a, en, c, rw, dn, bsy};
    endfunction

    // Common expectation shapes.
    function automatic logic [42:0] e_zero(input logic bsy);
        return ex(1'b0, 1'b0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b0, bsy);
    endfunction
    function automatic logic [42:0] e_start(input logic [31:0] a);
        return ex(1'b0, 1'b1, a, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endfunction
    function automatic logic [42:0] e_beat(input logic [31:0] a, input logic [4:0] c);
        return ex(1'b1, 1'b1, a, 1'b1, c, 1'b1, 1'b0, 1'b1);
    endfunction
    function automatic logic [42:0] e_last(input logic [4:0] c);
        return ex(1'b1, 1'b0, 32'h0, 1'b1, c, 1'b1, 1'b1, 1'b1);
    endfunction

    function automatic vec_t v(input logic r, input logic c, input logic vl, input logic rdy,
                               input logic [31:0] a, input logic [31:0] s, input logic [4:0] m,
                               input logic [4:0] n, input logic [42:0] e);
        vec_t t;
        t.rst = r; t.can = c; t.valid = vl; t.ready = rdy;
        t.addr = a; t.stride = s; t.m = m; t.n = n; t.exp = e;
        return t;
    endfunction

    task automatic apply(input vec_t t, input string nm, input int idx);
        logic [42:0] act;
        @(negedge clk);
        rst            = t.rst;
        can_store      = t.can;
        out_buff_valid = t.valid;
        mem_ready      = t.ready;
        tile_C_addr    = t.addr;
        tile_C_stride  = t.stride;
        msize          = t.m;
        nsize          = t.n;
        #1;
        act = {out_buff_read, gen_addr_store, next_row_addr_store, interface_en_store,
               interface_control_store, interface_rdwr_store, done_store, busy_store};
        checks++;
        if (act !== t.exp) begin
            errors++;
            $display("FAIL %s[%0d]: got {rd,gen,addr,en,ctrl,rw,done,busy}=%h required %h", nm, idx, act, t.exp);
        end
    endtask

    task automatic run_tbl(input string nm);
        for (int i = 0; i < tbl.size(); i++) apply(tbl[i], nm, i);
        tbl.delete();
    endtask

    initial begin
        rst = 1'b1; can_store = 1'b0; out_buff_valid = 1'b0; mem_ready = 1'b1;
        tile_C_addr = 32'h0; tile_C_stride = 32'h0; msize = 5'd0; nsize = 5'd0;

        // Reset state (can_store high during reset must not leak) and basic 4-row tile.
        // Config inputs are scrambled after start to show they are ignored.
        tbl.push_back(v(1, 1, 1, 1, 32'h1000, 32'h40, 5'd4, 5'd8, e_zero(0)));
        tbl.push_back(v(0, 0, 1, 1, 32'h1000, 32'h40, 5'd4, 5'd8, e_zero(0)));
        tbl.push_back(v(0, 1, 1, 1, 32'h1000, 32'h40, 5'd4, 5'd8, e_start(32'h1000)));
        tbl.push_back(v(0, 1, 1, 1, 32'hDEAD0000, 32'h7, 5'd1, 5'd3, e_beat(32'h1040, 5'd8)));
        tbl.push_back(v(0, 1, 1, 1, 32'hDEAD0000, 32'h7, 5'd1, 5'd3, e_beat(32'h1080, 5'd8)));
        tbl.push_back(v(0, 1, 1, 1, 32'hDEAD0000, 32'h7, 5'd1, 5'd3, e_beat(32'h10C0, 5'd8)));
        tbl.push_back(v(0, 1, 1, 1, 32'hDEAD0000, 32'h7, 5'd1, 5'd3, e_last(5'd8)));
        tbl.push_back(v(0, 0, 1, 1, 32'h1000, 32'h40, 5'd4, 5'd8, e_zero(0)));
        run_tbl("basic");

        // Stall: 5-cycle valid gap before row 2; row counter must hold.
        tbl.push_back(v(0, 1, 0, 1, 32'h3000, 32'h10, 5'd3, 5'd4, e_start(32'h3000)));
        tbl.push_back(v(0, 1, 1, 1, 32'h3000, 32'h10, 5'd3, 5'd4, e_beat(32'h3010, 5'd4)));
        for (int i = 0; i < 5; i++)
            tbl.push_back(v(0, 1, 0, 1, 32'h3000, 32'h10, 5'd3, 5'd4, e_zero(1)));
        tbl.push_back(v(0, 1, 1, 1, 32'h3000, 32'h10, 5'd3, 5'd4, e_beat(32'h3020, 5'd4)));
        tbl.push_back(v(0, 1, 1, 1, 32'h3000, 32'h10, 5'd3, 5'd4, e_last(5'd4)));
        tbl.push_back(v(0, 0, 0, 1, 32'h3000, 32'h10, 5'd3, 5'd4, e_zero(0)));
        run_tbl("stall");

        // Zero rows: bare done pulse; can_store held afterwards restarts, then abort.
        tbl.push_back(v(0, 1, 1, 1, 32'h5000, 32'h40, 5'd0, 5'd8, e_start(32'h5000)));
        tbl.push_back(v(0, 1, 1, 1, 32'h5000, 32'h40, 5'd0, 5'd8, ex(0, 0, 32'h0, 0, 5'd0, 0, 1, 1)));
        tbl.push_back(v(0, 1, 1, 1, 32'h5000, 32'h40, 5'd0, 5'd8, e_start(32'h5000)));
        tbl.push_back(v(0, 0, 1, 1, 32'h5000, 32'h40, 5'd0, 5'd8, e_zero(1)));
        tbl.push_back(v(0, 0, 1, 1, 32'h5000, 32'h40, 5'd0, 5'd8, e_zero(0)));
        run_tbl("zero_rows");

        // Abort after 2 beats, then restart at 0x2000 with a fresh sequence.
        tbl.push_back(v(0, 1, 1, 1, 32'h4000, 32'h100, 5'd6, 5'd2, e_start(32'h4000)));
        tbl.push_back(v(0, 1, 1, 1, 32'h4000, 32'h100, 5'd6, 5'd2, e_beat(32'h4100, 5'd2)));
        tbl.push_back(v(0, 1, 1, 1, 32'h4000, 32'h100, 5'd6, 5'd2, e_beat(32'h4200, 5'd2)));
        tbl.push_back(v(0, 0, 1, 1, 32'h4000, 32'h100, 5'd6, 5'd2, e_zero(1)));
        tbl.push_back(v(0, 0, 1, 1, 32'h4000, 32'h100, 5'd6, 5'd2, e_zero(0)));
        tbl.push_back(v(0, 1, 1, 1, 32'h2000, 32'h100, 5'd6, 5'd2, e_start(32'h2000)));
        tbl.push_back(v(0, 1, 1, 1, 32'h2000, 32'h100, 5'd6, 5'd2, e_beat(32'h2100, 5'd2)));
        tbl.push_back(v(0, 0, 1, 1, 32'h2000, 32'h100, 5'd6, 5'd2, e_zero(1)));
        tbl.push_back(v(0, 0, 1, 1, 32'h2000, 32'h100, 5'd6, 5'd2, e_zero(0)));
        run_tbl("abort");

        // Reset during beat 2 of a 5-row tile; the next start behaves like a fresh tile.
        tbl.push_back(v(0, 1, 1, 1, 32'h1000, 32'h40, 5'd5, 5'd8, e_start(32'h1000)));
        tbl.push_back(v(0, 1, 1, 1, 32'h1000, 32'h40, 5'd5, 5'd8, e_beat(32'h1040, 5'd8)));
        tbl.push_back(v(1, 1, 1, 1, 32'h1000, 32'h40, 5'd5, 5'd8, e_zero(0)));
        tbl.push_back(v(0, 1, 1, 1, 32'h1000, 32'h40, 5'd2, 5'd8, e_start(32'h1000)));
        tbl.push_back(v(0, 1, 1, 1, 32'h1000, 32'h40, 5'd2, 5'd8, e_beat(32'h1040, 5'd8)));
        tbl.push_back(v(0, 1, 1, 1, 32'h1000, 32'h40, 5'd2, 5'd8, e_last(5'd8)));
        tbl.push_back(v(0, 0, 1, 1, 32'h1000, 32'h40, 5'd2, 5'd8, e_zero(0)));
        run_tbl("reset_mid");

        // Address wrap modulo 2^32.
        tbl.push_back(v(0, 1, 1, 1, 32'hFFFF_FFC0, 32'h40, 5'd2, 5'd1, e_start(32'hFFFF_FFC0)));
        tbl.push_back(v(0, 1, 1, 1, 32'hFFFF_FFC0, 32'h40, 5'd2, 5'd1, e_beat(32'h0000_0000, 5'd1)));
        tbl.push_back(v(0, 1, 1, 1, 32'hFFFF_FFC0, 32'h40, 5'd2, 5'd1, e_last(5'd1)));
        tbl.push_back(v(0, 0, 1, 1, 32'hFFFF_FFC0, 32'h40, 5'd2, 5'd1, e_zero(0)));
        run_tbl("wrap");

        // Largest row count: 31 beats, done only on the 31st.
        tbl.push_back(v(0, 1, 1, 1, 32'h100, 32'h4, 5'd31, 5'd31, e_start(32'h100)));
        for (int k = 1; k <= 30; k++)
            tbl.push_back(v(0, 1, 1, 1, 32'h100, 32'h4, 5'd31, 5'd31, e_beat(32'h100 + 32'(4 * k), 5'd31)));
        tbl.push_back(v(0, 1, 1, 1, 32'h100, 32'h4, 5'd31, 5'd31, e_last(5'd31)));
        tbl.push_back(v(0, 0, 1, 1, 32'h100, 32'h4, 5'd31, 5'd31, e_zero(0)));
        run_tbl("m31");

`ifdef STORE_MEM_READY_EN
        // mem_ready low for 3 cycles delays beat 1 by 3 cycles.
        tbl.push_back(v(0, 1, 1, 0, 32'h6000, 32'h20, 5'd2, 5'd5, e_start(32'h6000)));
        for (int i = 0; i < 3; i++)
            tbl.push_back(v(0, 1, 1, 0, 32'h6000, 32'h20, 5'd2, 5'd5, e_zero(1)));
        tbl.push_back(v(0, 1, 1, 1, 32'h6000, 32'h20, 5'd2, 5'd5, e_beat(32'h6020, 5'd5)));
        tbl.push_back(v(0, 1, 1, 1, 32'h6000, 32'h20, 5'd2, 5'd5, e_last(5'd5)));
        tbl.push_back(v(0, 0, 1, 1, 32'h6000, 32'h20, 5'd2, 5'd5, e_zero(0)));
        run_tbl("mem_ready");
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
